// File: rtl/pattern_scan_pkg.sv
// Shared types and widths for the bit-serial pattern scanner.
package pattern_scan_pkg;

    localparam int WORD_W    = 8;
    localparam int PAT_W_MAX = 8;
    localparam int CNT_W     = 16;
    localparam int LEN_W     = $clog2(PAT_W_MAX + 1);
    localparam int IDX_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT
    } state_e;

    typedef struct packed {
        logic [PAT_W_MAX-1:0] pattern;
        logic [LEN_W-1:0]     len;
        logic                 overlap;
    } match_cfg_t;

    // Lengths beyond the history depth behave as a full-depth compare.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (int'(len) > PAT_W_MAX) return LEN_W'(PAT_W_MAX);
        return len;
    endfunction

endpackage

// File: rtl/pattern_scan_if.sv
// Word stream handshake between the upstream source and the scanner.
interface pattern_scan_if;

    logic [pattern_scan_pkg::WORD_W-1:0] in_data;
    logic                                in_valid;
    logic                                in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/serial_pattern_matcher.sv
// History shift register and masked compare; match is combinational on
// the bit being shifted in this cycle.
module serial_pattern_matcher
    import pattern_scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_en,
    input  logic       clear,
    input  match_cfg_t cfg,
    output logic       match
);

    logic [PAT_W_MAX-1:0] hist_q, hist_d, hist_new, mask;
    logic [LEN_W-1:0]     vcnt_q, vcnt_d, vcnt_inc;

    always_comb begin
        hist_new = {hist_q[PAT_W_MAX-2:0], bit_in};
        vcnt_inc = (int'(vcnt_q) >= PAT_W_MAX) ? vcnt_q : vcnt_q + 1'b1;
        mask     = '0;
        for (int i = 0; i < PAT_W_MAX; i++) begin
            if (i < int'(cfg.len)) mask[i] = 1'b1;
        end
        match = bit_en && (cfg.len != '0) &&
                (((hist_new ^ cfg.pattern) & mask) == '0) &&
                (vcnt_inc >= cfg.len);
        hist_d = hist_q;
        vcnt_d = vcnt_q;
        if (clear) begin
            hist_d = '0;
            vcnt_d = '0;
        end else if (bit_en) begin
            hist_d = hist_new;
            // Non-overlapping mode: bits of a match cannot be reused.
            vcnt_d = (match && !cfg.overlap) ? '0 : vcnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            vcnt_q <= '0;
        end else begin
            hist_q <= hist_d;
            vcnt_q <= vcnt_d;
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Word-to-bit sequencer, match counter and sticky threshold interrupt
// in front of the serial pattern matcher.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [PAT_W_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic                 cfg_overlap,
    input  logic [CNT_W-1:0]     threshold,
    pattern_scan_if.slave        in_if,
    output logic                 busy,
    output logic                 match_pulse,
    output logic [CNT_W-1:0]     match_count,
    output logic                 irq,
    input  logic                 irq_clr
);

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               stop_q, stop_d;
    match_cfg_t         cfg_q, cfg_d;
    logic [CNT_W-1:0]   thr_q, thr_d;
    logic               pulse_q, pulse_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_q, irq_d;

    logic ready, accept, stop_now, clear, shift_en, match, irq_set;

    serial_pattern_matcher u_matcher (
        .clk    (clk),
        .rst    (rst),
        .bit_in (word_q[idx_q]),
        .bit_en (shift_en),
        .clear  (clear),
        .cfg    (cfg_q),
        .match  (match)
    );

    always_comb begin
        ready    = (state_q == WAIT) ||
                   ((state_q == SHIFT) && (idx_q == '0));
        accept   = ready && in_if.in_valid;
        stop_now = stop_q | stop;
        shift_en = (state_q == SHIFT);
        clear    = 1'b0;
        state_d  = state_q;
        word_d   = word_q;
        idx_d    = idx_q;
        stop_d   = stop_q;
        cfg_d    = cfg_q;
        thr_d    = thr_q;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (start) begin
                    state_d       = WAIT;
                    cfg_d.pattern = cfg_pattern;
                    cfg_d.len     = clamp_len(cfg_len);
                    cfg_d.overlap = cfg_overlap;
                    thr_d         = threshold;
                    clear         = 1'b1;
                end
            end
            (state_q == WAIT): begin
                stop_d = stop_now;
                if (accept) begin
                    state_d = SHIFT;
                    word_d  = in_if.in_data;
                    idx_d   = IDX_W'(WORD_W - 1);
                end else if (stop_now) begin
                    state_d = IDLE;
                    stop_d  = 1'b0;
                end
            end
            (state_q == SHIFT): begin
                stop_d = stop_now;
                idx_d  = idx_q - 1'b1;
                if (idx_q == '0) begin
                    if (accept) begin
                        word_d = in_if.in_data;
                        idx_d  = IDX_W'(WORD_W - 1);
                    end else if (stop_now) begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                stop_d  = 1'b0;
            end
        endcase

        pulse_d = match;
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (match && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
        irq_set = match && (count_q != CNT_MAX) && (thr_q != '0) &&
                  ((count_q + 1'b1) == thr_q);
        irq_d   = irq_set | (irq_q & ~irq_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            cfg_q   <= '0;
            thr_q   <= '0;
            pulse_q <= 1'b0;
            count_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            cfg_q   <= cfg_d;
            thr_q   <= thr_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
            irq_q   <= irq_d;
        end
    end

    assign in_if.in_ready = ready;
    assign busy           = (state_q != IDLE);
    assign match_pulse    = pulse_q;
    assign match_count    = count_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: timing, overlap, word boundary,
// irq priority, stop/start handling, length limits and reset.
module tb_pattern_scan_ctrl;
    import pattern_scan_pkg::*;

    logic             clk = 1'b0;
    logic             rst, start, stop, cfg_overlap, irq_clr;
    logic [7:0]       cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic [15:0]      threshold, match_count;
    logic             busy, match_pulse, irq;
    int               checks = 0;
    int               failures = 0;

    pattern_scan_if bus ();

    pattern_scan_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .threshold   (threshold),
        .in_if       (bus),
        .busy        (busy),
        .match_pulse (match_pulse),
        .match_count (match_count),
        .irq         (irq),
        .irq_clr     (irq_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [7:0] pat, input int len,
                             input logic ov, input logic [15:0] thr);
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ov;
        threshold   = thr;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic count_pulses(input int n, output int p);
        p = 0;
        for (int i = 0; i < n; i++) begin
            if (match_pulse === 1'b1) p++;
            step();
        end
    endtask

    task automatic go_idle();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({bus.in_ready, busy, match_pulse, irq} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got %b want 0000",
                     {bus.in_ready, busy, match_pulse, irq});
        end
        checks++;
        if (match_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_count got %0d want 0", match_count);
        end
    endtask

    task automatic test_single_match();
        begin_run(8'b0001_1010, 5, 1'b1, 16'd0);
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL wait_ready got %b%b want 11", bus.in_ready, busy);
        end
        send_word(8'hD0);
        for (int t = 1; t <= 8; t++) begin
            checks++;
            if (match_pulse !== 1'(t == 6)) begin
                failures++;
                $display("FAIL d0_pulse T%0d got %b want %b",
                         t, match_pulse, (t == 6));
            end
            checks++;
            if (bus.in_ready !== 1'(t == 8)) begin
                failures++;
                $display("FAIL d0_ready T%0d got %b want %b",
                         t, bus.in_ready, (t == 8));
            end
            step();
        end
        checks++;
        if (match_count !== 16'd1) begin
            failures++;
            $display("FAIL d0_count got %0d want 1", match_count);
        end
        go_idle();
    endtask

    task automatic test_overlap();
        int p;
        begin_run(8'b101, 3, 1'b1, 16'd0);
        send_word(8'hAA);
        count_pulses(9, p);
        checks++;
        if (p != 3 || match_count !== 16'd3) begin
            failures++;
            $display("FAIL ovl1 got p=%0d c=%0d want 3 3", p, match_count);
        end
        go_idle();
        begin_run(8'b101, 3, 1'b0, 16'd0);
        checks++;
        if (match_count !== 16'd0) begin
            failures++;
            $display("FAIL start_clear got %0d want 0", match_count);
        end
        send_word(8'hAA);
        count_pulses(9, p);
        checks++;
        if (p != 2 || match_count !== 16'd2) begin
            failures++;
            $display("FAIL ovl0 got p=%0d c=%0d want 2 2", p, match_count);
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        begin_run(8'b0110, 4, 1'b1, 16'd0);
        send_word(8'h01);
        repeat (7) step();
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready got %b%b want 11", bus.in_ready, busy);
        end
        send_word(8'h80);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_gap got %b want 0", bus.in_ready);
        end
        for (int t = 9; t <= 17; t++) begin
            checks++;
            if (match_pulse !== 1'(t == 11)) begin
                failures++;
                $display("FAIL b2b_pulse T%0d got %b want %b",
                         t, match_pulse, (t == 11));
            end
            step();
        end
        checks++;
        if (match_count !== 16'd1) begin
            failures++;
            $display("FAIL b2b_count got %0d want 1", match_count);
        end
        go_idle();
    endtask

    task automatic test_irq();
        int p;
        begin_run(8'b1, 1, 1'b1, 16'd2);
        send_word(8'h03);
        repeat (7) step();
        checks++;
        if (match_pulse !== 1'b1 || irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_first got p=%b i=%b want 1 0", match_pulse, irq);
        end
        irq_clr = 1'b1;
        step();
        checks++;
        if (match_pulse !== 1'b1 || match_count !== 16'd2 || irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_set_wins got p=%b c=%0d i=%b want 1 2 1",
                     match_pulse, match_count, irq);
        end
        step();
        irq_clr = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_clear got %b want 0", irq);
        end
        go_idle();
        begin_run(8'b1, 1, 1'b1, 16'd0);
        send_word(8'hFF);
        count_pulses(9, p);
        checks++;
        if (match_count !== 16'd8 || irq !== 1'b0) begin
            failures++;
            $display("FAIL thr0 got c=%0d i=%b want 8 0", match_count, irq);
        end
        go_idle();
    endtask

    task automatic test_stop_start();
        begin_run(8'b1, 1, 1'b1, 16'd0);
        send_word(8'hFF);
        step();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        cfg_pattern = 8'h00;
        cfg_len     = '0;
        start       = 1'b1;
        step();
        start       = 1'b0;
        for (int t = 5; t <= 8; t++) begin
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL stop_busy T%0d got %b want 1", t, busy);
            end
            step();
        end
        checks++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stop_idle got %b%b want 00", busy, bus.in_ready);
        end
        checks++;
        if (match_count !== 16'd8) begin
            failures++;
            $display("FAIL stop_count got %0d want 8", match_count);
        end
    endtask

    task automatic test_len_bounds();
        int p;
        begin_run(8'h00, 0, 1'b1, 16'd0);
        send_word(8'h00);
        count_pulses(9, p);
        checks++;
        if (p != 0 || match_count !== 16'd0) begin
            failures++;
            $display("FAIL len0 got p=%0d c=%0d want 0 0", p, match_count);
        end
        go_idle();
        begin_run(8'hA5, 15, 1'b1, 16'd0);
        send_word(8'hA5);
        count_pulses(9, p);
        checks++;
        if (p != 1 || match_count !== 16'd1) begin
            failures++;
            $display("FAIL len_clamp got p=%0d c=%0d want 1 1", p, match_count);
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        begin_run(8'b1, 1, 1'b1, 16'd2);
        send_word(8'hFF);
        repeat (3) step();
        checks++;
        if (irq !== 1'b1 || match_count !== 16'd3) begin
            failures++;
            $display("FAIL pre_rst got i=%b c=%0d want 1 3", irq, match_count);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({bus.in_ready, busy, match_pulse, irq} !== 4'b0000 ||
            match_count !== 16'd0) begin
            failures++;
            $display("FAIL mid_rst got %b c=%0d want 0000 0",
                     {bus.in_ready, busy, match_pulse, irq}, match_count);
        end
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || match_pulse !== 1'b0) begin
            failures++;
            $display("FAIL post_rst got %b%b want 00", busy, match_pulse);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        irq_clr      = 1'b0;
        cfg_pattern  = '0;
        cfg_len      = '0;
        cfg_overlap  = 1'b0;
        threshold    = '0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        test_reset();
        test_single_match();
        test_overlap();
        test_back_to_back();
        test_irq();
        test_stop_start();
        test_len_bounds();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Controller that feeds a parallel word stream into a bit-serial, programmable pattern matcher.
- Sequences each accepted word MSB-first, one bit per cycle, and counts pattern occurrences.
- Raises a sticky interrupt when the match count reaches a programmed threshold.
- Sits between a word-oriented upstream source (valid/ready) and a CPU-visible status/interrupt interface.

Parameters:
- WORD_W, 8, bits per input word.
- PAT_W_MAX, 8, maximum pattern length in bits.
- CNT_W, 16, match counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  pulse: latch config and begin a run (honoured only in IDLE)
- stop  in  1  pulse: finish the current word, then return to IDLE
- cfg_pattern  in  PAT_W_MAX  pattern bits; bit 0 = last-received bit
- cfg_len  in  $clog2(PAT_W_MAX+1)  pattern length in bits
- cfg_overlap  in  1  1 = overlapping matches counted
- threshold  in  CNT_W  irq trigger count
- in_data  in  WORD_W  input word
- in_valid  in  1  input word valid
- in_ready  out  1  controller accepts a word
- busy  out  1  high when not IDLE
- match_pulse  out  1  one-cycle pulse per match
- match_count  out  CNT_W  matches this run, saturating
- irq  out  1  sticky threshold-reached flag
- irq_clr  in  1  clears irq

Behaviour:
- Reset: state IDLE. in_ready=0, busy=0, match_pulse=0, match_count=0, irq=0. History and bit counters cleared.
- States:
  - IDLE: start → WAIT. On the start cycle: latch cfg_pattern, cfg_len, cfg_overlap and threshold; clear history, valid-bit counter and match_count. irq is untouched.
  - WAIT: in_ready=1. Handshake in_valid&in_ready → latch word, go to SHIFT with bit index WORD_W-1. If a stop is pending and no word is accepted, go to IDLE.
  - SHIFT: each cycle, shift bit[idx] into the history register and decrement idx.
    - On the idx==0 cycle, in_ready=1, allowing back-to-back words (one word per WORD_W cycles).
    - If a word is accepted on that cycle, stay in SHIFT with idx=WORD_W-1.
    - Otherwise go to WAIT, or to IDLE if a stop is pending.
- stop: recorded as pending in any non-IDLE state. It never aborts a word mid-shift. Pending stop is cleared on entry to IDLE.
- start outside IDLE: ignored.
- History persists across word boundaries within a run.
- Match condition, evaluated on the shifted bit:
  - low L bits of the new history equal low L bits of the pattern, where L = min(cfg_len, PAT_W_MAX);
  - valid-bit counter ≥ L;
  - L ≠ 0. L=0 never matches.
- Valid-bit counter: counts bits since run start, saturating at PAT_W_MAX. On a match with cfg_overlap=0, it is reset to 0.
- Latency: match_pulse is registered and asserts the cycle after the completing bit is shifted. match_count updates on the same cycle as match_pulse.
- match_count saturates at 2^CNT_W-1.
- irq: set on the cycle match_count transitions to a value == threshold. threshold=0 never sets irq.
  - irq_clr clears irq.
  - If set and clear coincide, set wins.
- Reset mid-operation: immediate return to reset values. A partially shifted word is discarded.

Decomposition:
- Shared package pattern_scan_pkg holds:
  - state enum {IDLE, WAIT, SHIFT};
  - localparam widths derived from WORD_W, PAT_W_MAX, CNT_W;
  - the L-clamp function.
- Sub-module serial_pattern_matcher holds the history shift register, valid-bit counter, mask/compare logic and overlap handling. Interface: bit_in, bit_en, clear, cfg → match.
- pattern_scan_ctrl holds the FSM, handshake, counter and irq.

Test Plan:
- Pattern 11010, L=5, overlap=1, word 0xD0 accepted at T0 → bits on T1..T8, match_pulse only at T6, match_count=1, in_ready high at T8.
- Pattern 101, L=3, word 0xAA → overlap=1: 3 pulses, count=3. Re-run with overlap=0: 2 pulses, count=2.
- Pattern 0110, L=4, words 0x01 then 0x80 back-to-back → single match spanning the boundary. Second word accepted on the idx==0 cycle with no gap.
- threshold=2, pattern 1, L=1, word 0x03 → irq rises with the second match_pulse. Assert irq_clr on that same cycle → irq stays 1. irq_clr one cycle later → irq=0.
- stop asserted mid-word → remaining bits still shifted, busy drops the cycle after the last bit. start while busy is ignored (count not cleared).
- rst asserted during SHIFT → next cycle in_ready=0, busy=0, match_count=0, irq=0, and no match_pulse.
